sample_strobe_gen: RTL and testbench

Parametrised sample/shift timing generator for the FSK demodulator datapath. It is a free-running modulo-PERIOD counter that issues a frame-aligned SAMP strobe and a SHIFT enable with a configurable suppression gap. It adds N_CH phase-staggered per-channel sample strobes, a runtime-reloadable period (shadowed, applied only at wrap), clock enable, and phase resync. It sits between the system clock and the correlator/shift-register bank.

---
 rtl/mbsfsk_timing_pkg.sv | 15 +
 rtl/sample_phase_decode.sv | 26 ++
 rtl/sample_strobe_gen.sv | 97 +++++++++
 tb/tb_sample_strobe_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbsfsk_timing_pkg.sv
// Shared timing constants for the FSK demodulator sample/shift generator.
// Holds the reset defaults, the smallest legal period and the offset-slice helper.
package mbsfsk_timing_pkg;

    localparam int CNT_W_DEFAULT      = 7;
    localparam int DEF_PERIOD_DEFAULT = 127;
    localparam int N_CH_DEFAULT       = 4;
    localparam int MIN_PERIOD         = 2;

    // LSB of channel ch's phase offset inside the packed OFFSETS bus.
    function automatic int ch_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/sample_phase_decode.sv
// Per-channel phase strobe: fires one cycle after an advance lands on the channel offset.
// Offsets at or beyond the active period are simply never matched.
module sample_phase_decode #(
    parameter int CNT_W = 7
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [CNT_W-1:0] i_next_count,
    input  logic [CNT_W-1:0] i_offset,
    input  logic             i_advance,
    output logic             o_samp
);

    logic r_samp;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_samp <= 1'b0;
        end else begin
            r_samp <= i_advance && (i_next_count == i_offset);
        end
    end

    assign o_samp = r_samp;

endmodule

// File: rtl/sample_strobe_gen.sv
// Free-running modulo-period phase counter producing SAMP, per-channel SAMP_CH and SHIFT,
// with a shadowed runtime period that only takes effect at a wrap.
module sample_strobe_gen
    import mbsfsk_timing_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int DEF_PERIOD = DEF_PERIOD_DEFAULT,
    parameter int N_CH       = N_CH_DEFAULT,
    parameter int SHIFT_GAP  = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  SYNC,
    input  logic [CNT_W-1:0]      PERIOD_IN,
    input  logic                  PERIOD_LD,
    input  logic [N_CH*CNT_W-1:0] OFFSETS,
    output logic [CNT_W-1:0]      COUNT,
    output logic                  SAMP,
    output logic [N_CH-1:0]       SAMP_CH,
    output logic                  SHIFT,
    output logic                  PERIOD_PEND,
    output logic                  PERIOD_ERR
);

    localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_V   = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(SHIFT_GAP);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_err;
    logic             r_samp;
    logic             r_shift;

    logic             w_last;
    logic             w_wrap;
    logic             w_ld_ok;
    logic [CNT_W-1:0] w_next_count;

    // SYNC on the last count collapses into the same single wrap as a natural one.
    assign w_last       = (r_count == (r_active - ONE_V));
    assign w_wrap       = EN && (w_last || SYNC);
    assign w_ld_ok      = PERIOD_LD && (PERIOD_IN >= MIN_V);
    assign w_next_count = !EN    ? r_count :
                          w_wrap ? '0      : (r_count + ONE_V);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_count  <= '0;
            r_active <= DEF_V;
            r_shadow <= DEF_V;
            r_pend   <= 1'b0;
            r_err    <= 1'b0;
            r_samp   <= 1'b0;
            r_shift  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_samp  <= w_wrap;
            r_shift <= EN && (w_next_count >= GAP_V);
            r_err   <= PERIOD_LD && (PERIOD_IN < MIN_V);
            if (w_wrap && r_pend) begin
                r_active <= r_shadow;
                r_pend   <= 1'b0;
            end
            // A load coinciding with a wrap lands after the old shadow was applied above.
            if (w_ld_ok) begin
                r_shadow <= PERIOD_IN;
                r_pend   <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam int LSB = ch_lsb(g, CNT_W);
        sample_phase_decode #(
            .CNT_W(CNT_W)
        ) u_decode (
            .CLOCK        (CLOCK),
            .RESET        (RESET),
            .i_next_count (w_next_count),
            .i_offset     (OFFSETS[LSB +: CNT_W]),
            .i_advance    (EN),
            .o_samp       (SAMP_CH[g])
        );
    end

    assign COUNT       = r_count;
    assign SAMP        = r_samp;
    assign SHIFT       = r_shift;
    assign PERIOD_PEND = r_pend;
    assign PERIOD_ERR  = r_err;

endmodule

// File: tb/tb_sample_strobe_gen.sv
// Bench for sample_strobe_gen: directed scenarios with literal expectations, then random
// traffic checked every cycle against an arithmetic frame model.
module tb_sample_strobe_gen;

    localparam int CNT_W      = 7;
    localparam int DEF_PERIOD = 127;
    localparam int N_CH       = 4;
    localparam int SHIFT_GAP  = 1;
    localparam int W          = CNT_W + 1 + N_CH + 3;

    logic                  CLOCK = 1'b0;
    logic                  RESET = 1'b1;
    logic                  en = 1'b0;
    logic                  sync = 1'b0;
    logic [CNT_W-1:0]      period_in = '0;
    logic                  period_ld = 1'b0;
    logic [N_CH*CNT_W-1:0] offsets = '0;
    logic [CNT_W-1:0]      count;
    logic                  samp;
    logic [N_CH-1:0]       samp_ch;
    logic                  shift;
    logic                  period_pend;
    logic                  period_err;

    int tests = 0;
    int fails = 0;

    sample_strobe_gen #(
        .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .N_CH(N_CH), .SHIFT_GAP(SHIFT_GAP)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .EN(en), .SYNC(sync),
        .PERIOD_IN(period_in), .PERIOD_LD(period_ld), .OFFSETS(offsets),
        .COUNT(count), .SAMP(samp), .SAMP_CH(samp_ch), .SHIFT(shift),
        .PERIOD_PEND(period_pend), .PERIOD_ERR(period_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLOCK = ~CLOCK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural frame model ----------------
    int         m_count;
    int         m_period;
    int         m_shadow;
    bit         m_pend;
    bit         m_wrap;
    int         m_nxt;
    logic       e_samp;
    logic       e_shift;
    logic       e_err;
    logic [N_CH-1:0] e_ch;
    logic [W-1:0] exp_q[$];

    always @(posedge CLOCK) begin
        if (RESET) begin
            m_count  = 0;
            m_period = DEF_PERIOD;
            m_shadow = DEF_PERIOD;
            m_pend   = 1'b0;
            e_samp   = 1'b0;
            e_shift  = 1'b0;
            e_err    = 1'b0;
            e_ch     = '0;
        end else begin
            e_err  = period_ld && (int'(period_in) < 2);
            m_wrap = 1'b0;
            m_nxt  = m_count;
            if (en) begin
                m_wrap = sync || (((m_count + 1) % m_period) == 0);
                m_nxt  = m_wrap ? 0 : m_count + 1;
                if (m_wrap && m_pend) begin
                    m_period = m_shadow;
                    m_pend   = 1'b0;
                end
            end
            e_samp  = en && m_wrap;
            e_shift = en && (m_nxt >= SHIFT_GAP);
            for (int i = 0; i < N_CH; i++)
                e_ch[i] = en && (m_nxt == int'(offsets[i*CNT_W +: CNT_W]));
            if (period_ld && int'(period_in) >= 2) begin
                m_shadow = int'(period_in);
                m_pend   = 1'b1;
            end
            m_count = m_nxt;
        end
        exp_q.push_back({CNT_W'(m_count), e_samp, e_ch, e_shift, m_pend, e_err});
    end

    // ---------------- scoreboard compare ----------------
    logic [W-1:0] sb_exp;
    logic [W-1:0] sb_act;

    always @(negedge CLOCK) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {count, samp, samp_ch, shift, period_pend, period_err};
            tests++;
            if (sb_act !== sb_exp) begin
                fails++;
                $display("FAIL model_cycle t=%0t actual {cnt,samp,ch,shift,pend,err}=%h required %h",
                         $time, sb_act, sb_exp);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_samp(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!samp && n < 300);
    endtask

    task automatic load(input int p);
        period_in = CNT_W'(p);
        period_ld = 1'b1;
        cyc(1);
        period_ld = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    int n;
    int c_samp, c_ch1, c_ch2;

    initial begin
        offsets = {7'd100, 7'd64, 7'd10, 7'd0};
        cyc(3);
        check("reset_count", int'(count), 0);
        check("reset_outs", int'({samp, samp_ch, shift, period_pend, period_err}), 0);
        check("model_reset_period", m_period, 127);

        // Default free run
        RESET = 1'b0;
        en    = 1'b1;
        cyc(126);
        check("run_count126", int'(count), 126);
        check("run_shift126", int'(shift), 1);
        cyc(1);
        check("first_samp_count", int'(count), 0);
        check("first_samp", int'(samp), 1);
        check("first_samp_shift", int'(shift), 0);
        check("ch0_with_samp", int'(samp_ch), 4'b0001);
        cyc(10);
        check("ch1_at_10", int'(samp_ch), 4'b0010);
        cyc(54);
        check("ch2_at_64", int'(samp_ch), 4'b0100);
        wait_samp(n);
        check("samp_gap_from64", n, 63);
        wait_samp(n);
        check("samp_period_127", n, 127);

        // Load 40 mid-frame
        cyc(20);
        load(40);
        check("pend_after_load", int'(period_pend), 1);
        check("count_after_load", int'(count), 21);
        wait_samp(n);
        check("old_frame_rest", n, 106);
        check("pend_clear_at_wrap", int'(period_pend), 0);
        wait_samp(n);
        check("frame_40", n, 40);
        check("model_period_40", m_period, 40);

        // Period 100, out-of-range channel offset
        load(100);
        wait_samp(n);
        check("frame_40_tail", n, 39);
        offsets[2*CNT_W +: CNT_W] = 7'd127;
        c_samp = 0; c_ch1 = 0; c_ch2 = 0;
        repeat (200) begin
            cyc(1);
            c_samp += int'(samp);
            c_ch1  += int'(samp_ch[1]);
            c_ch2  += int'(samp_ch[2]);
        end
        check("samps_in_200", c_samp, 2);
        check("ch1_fires", c_ch1, 2);
        check("ch2_never", c_ch2, 0);

        // Rejected loads
        load(1);
        check("err_in1", int'(period_err), 1);
        check("pend_in1", int'(period_pend), 0);
        load(0);
        check("err_in0", int'(period_err), 1);
        cyc(1);
        check("err_cleared", int'(period_err), 0);
        wait_samp(n);
        check("frame_after_err", n, 97);
        wait_samp(n);
        check("period_kept_100", n, 100);

        // SYNC with pending load
        cyc(50);
        load(30);
        cyc(6);
        check("count57", int'(count), 57);
        check("pend_before_sync", int'(period_pend), 1);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        check("sync_count", int'(count), 0);
        check("sync_samp", int'(samp), 1);
        check("sync_pend", int'(period_pend), 0);
        wait_samp(n);
        check("frame_30", n, 30);

        // Hold with EN=0, then reset with a load pending
        load(127);
        wait_samp(n);
        check("frame_30_tail", n, 29);
        cyc(90);
        en = 1'b0;
        load(50);
        check("hold_count", int'(count), 90);
        check("hold_strobes", int'({samp, samp_ch, shift}), 0);
        check("hold_pend", int'(period_pend), 1);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        cyc(3);
        check("hold_count_sync", int'(count), 90);
        RESET = 1'b1;
        cyc(1);
        check("mid_reset_count", int'(count), 0);
        check("mid_reset_outs", int'({samp, samp_ch, shift, period_pend, period_err}), 0);
        RESET = 1'b0;
        en    = 1'b1;
        wait_samp(n);
        check("period_back_127", n, 127);

        // Random traffic
        repeat (4000) begin
            RESET     = ($urandom_range(0, 499) == 0);
            en        = ($urandom_range(0, 9) != 0);
            sync      = ($urandom_range(0, 29) == 0);
            period_ld = ($urandom_range(0, 19) == 0);
            period_in = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 127))
                                                     : CNT_W'($urandom_range(0, 24));
            if ($urandom_range(0, 49) == 0)
                for (int i = 0; i < N_CH; i++)
                    offsets[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 30));
            cyc(1);
        end
        RESET = 1'b0; en = 1'b0; sync = 1'b0; period_ld = 1'b0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
